// File: rtl/p21_pkg.sv
// Shared constants and state type for the per-frame game-logic scheduler.
// Screen coordinates follow the 640x480 VGA timing generator.
package p21_pkg;
   localparam int V_ACTIVE = 480;
   localparam int V_TOTAL  = 525;
   localparam int H_TOTAL  = 800;

   localparam logic [9:0] FS_V = 10'(V_ACTIVE);
   localparam logic [9:0] FS_H = 10'd0;
   localparam logic [9:0] DL_V = 10'd0;
   localparam logic [9:0] DL_H = 10'd0;

   typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
endpackage

// File: rtl/p21_task_pick.sv
// Priority finder: lowest set mask bit at or above (incl) / above (!incl) start.
module p21_task_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] start,
   input  logic          incl,
   output logic          found,
   output logic [IW-1:0] idx
);
   always_comb begin
      found = 1'b0;
      idx   = '0;
      // Scan downward so the lowest qualifying index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i] && (incl ? (IW'(i) >= start) : (IW'(i) > start))) begin
            found = 1'b1;
            idx   = IW'(i);
         end
      end
   end
endmodule

// File: rtl/p21_frame_sched.sv
// Runs the game-logic engines one at a time during vblank and flags
// a deadline miss if the window closes before the masked set completes.
//
//   state | meaning
//   IDLE  | waiting for frame start; no request outstanding
//   REQ   | one-hot request held to engine cur until its done
//   GAP   | single all-low cycle between consecutive requests
module p21_frame_sched #(
   parameter int NUM_TASKS = 4,
   parameter int V_ACTIVE  = 480,
   parameter int FC_W      = 16,
   localparam int IW       = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1
) (
   input  logic                 clk,
   input  logic                 sys_rst,
   input  logic                 enable,
   input  logic [9:0]           vaddr,
   input  logic [9:0]           haddr,
   input  logic [NUM_TASKS-1:0] task_mask,
   output logic [NUM_TASKS-1:0] task_req,
   input  logic [NUM_TASKS-1:0] task_done,
   output logic                 busy,
   output logic                 frame_tick,
   output logic [FC_W-1:0]      frame_count,
   output logic                 overrun,
   output logic [IW-1:0]        overrun_task,
   input  logic                 overrun_clr
);
   import p21_pkg::*;

   localparam logic [NUM_TASKS-1:0] ONE = NUM_TASKS'(1);

   state_t               state;
   logic [NUM_TASKS-1:0] mask_q;
   logic [IW-1:0]        cur;
   logic                 fs, dl;
   logic                 fs_found, nxt_found;
   logic [IW-1:0]        fs_idx, nxt_idx;

   assign fs = (vaddr == 10'(V_ACTIVE)) && (haddr == FS_H);
   assign dl = (vaddr == DL_V) && (haddr == DL_H);

   p21_task_pick #(.N(NUM_TASKS)) u_pick_fs (
      .mask  (task_mask),
      .start ('0),
      .incl  (1'b1),
      .found (fs_found),
      .idx   (fs_idx)
   );

   p21_task_pick #(.N(NUM_TASKS)) u_pick_nxt (
      .mask  (mask_q),
      .start (cur),
      .incl  (1'b0),
      .found (nxt_found),
      .idx   (nxt_idx)
   );

   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state        <= IDLE;
         mask_q       <= '0;
         cur          <= '0;
         task_req     <= '0;
         busy         <= 1'b0;
         frame_tick   <= 1'b0;
         frame_count  <= '0;
         overrun      <= 1'b0;
         overrun_task <= '0;
      end else begin
         frame_tick <= fs;
         if (fs)
            frame_count <= frame_count + 1'b1;
         // Any overrun set further down overrides this clear.
         if (overrun_clr)
            overrun <= 1'b0;

         unique case (state)
            IDLE: begin
               if (fs && enable) begin
                  mask_q <= task_mask;
                  if (fs_found) begin
                     state    <= REQ;
                     cur      <= fs_idx;
                     task_req <= ONE << fs_idx;
                     busy     <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (dl) begin
                  state    <= IDLE;
                  task_req <= '0;
                  busy     <= 1'b0;
                  // A done on the deadline cycle still completes the task.
                  if (!task_done[cur] || nxt_found) begin
                     overrun      <= 1'b1;
                     overrun_task <= task_done[cur] ? nxt_idx : cur;
                  end
               end else if (task_done[cur]) begin
                  state    <= GAP;
                  task_req <= '0;
               end
            end
            GAP: begin
               if (dl) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (nxt_found) begin
                     overrun      <= 1'b1;
                     overrun_task <= nxt_idx;
                  end
               end else if (nxt_found) begin
                  state    <= REQ;
                  cur      <= nxt_idx;
                  task_req <= ONE << nxt_idx;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               task_req <= '0;
               busy     <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_p21_frame_sched.sv
// Directed bench for the frame scheduler; inputs change 1 ns after the
// rising edge and outputs are sampled at the same point.
module tb_p21_frame_sched;
   logic        clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        enable = 1'b0;
   logic [9:0]  vaddr = 10'd100;
   logic [9:0]  haddr = 10'd5;
   logic [3:0]  task_mask = 4'b0000;
   logic [3:0]  task_req;
   logic [3:0]  task_done = 4'b0000;
   logic        busy;
   logic        frame_tick;
   logic [15:0] frame_count;
   logic        overrun;
   logic [1:0]  overrun_task;
   logic        overrun_clr = 1'b0;

   int n_chk = 0;
   int n_pass = 0;
   int n_fail = 0;

   p21_frame_sched #(.NUM_TASKS(4), .V_ACTIVE(480), .FC_W(16)) dut (
      .clk          (clk),
      .sys_rst      (sys_rst),
      .enable       (enable),
      .vaddr        (vaddr),
      .haddr        (haddr),
      .task_mask    (task_mask),
      .task_req     (task_req),
      .task_done    (task_done),
      .busy         (busy),
      .frame_tick   (frame_tick),
      .frame_count  (frame_count),
      .overrun      (overrun),
      .overrun_task (overrun_task),
      .overrun_clr  (overrun_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame_start();
      vaddr = 10'd480; haddr = 10'd0;
      step();
      vaddr = 10'd100; haddr = 10'd5;
   endtask

   // Engine answers lat cycles after its request first became visible.
   task automatic run_task(input logic [3:0] exp_req, input int lat);
      chk("req_on", {28'd0, task_req}, {28'd0, exp_req});
      repeat (lat - 1) step();
      chk("req_held", {28'd0, task_req}, {28'd0, exp_req});
      task_done = exp_req;
      step();
      task_done = 4'b0000;
      chk("gap_low", {28'd0, task_req}, 32'd0);
   endtask

   task automatic pulse_reset();
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
      step();
   endtask

   initial begin
      step();
      step();
      sys_rst = 1'b0;
      step();
      chk("rst_req", {28'd0, task_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_tick", {31'd0, frame_tick}, 32'd0);
      chk("rst_fc", {16'd0, frame_count}, 32'd0);
      chk("rst_ovr", {31'd0, overrun}, 32'd0);

      // Three-task sequence with gaps
      enable = 1'b1; task_mask = 4'b1011;
      frame_start();
      chk("t1_tick", {31'd0, frame_tick}, 32'd1);
      chk("t1_busy", {31'd0, busy}, 32'd1);
      chk("t1_fc", {16'd0, frame_count}, 32'd1);
      run_task(4'b0001, 3);
      chk("t1_tick_off", {31'd0, frame_tick}, 32'd0);
      step();
      run_task(4'b0010, 3);
      step();
      run_task(4'b1000, 3);
      chk("t1_busy_gap", {31'd0, busy}, 32'd1);
      step();
      chk("t1_busy_end", {31'd0, busy}, 32'd0);
      chk("t1_req_end", {28'd0, task_req}, 32'd0);
      chk("t1_ovr", {31'd0, overrun}, 32'd0);

      // Task 2 hangs; deadline aborts the frame
      task_mask = 4'b0110;
      frame_start();
      run_task(4'b0010, 2);
      step();
      chk("t3_req2", {28'd0, task_req}, 32'h4);
      repeat (3) step();
      frame_start();
      chk("t3_fs_busy_tick", {31'd0, frame_tick}, 32'd1);
      chk("t3_fs_busy_req", {28'd0, task_req}, 32'h4);
      chk("t3_fs_busy_fc", {16'd0, frame_count}, 32'd3);
      step();
      vaddr = 10'd0; haddr = 10'd0;
      step();
      vaddr = 10'd100; haddr = 10'd5;
      chk("t3_ovr", {31'd0, overrun}, 32'd1);
      chk("t3_ovr_task", {30'd0, overrun_task}, 32'd2);
      chk("t3_req_drop", {28'd0, task_req}, 32'd0);
      chk("t3_busy_drop", {31'd0, busy}, 32'd0);
      frame_start();
      run_task(4'b0010, 1);
      step();
      run_task(4'b0100, 1);
      step();
      chk("t3_busy_end", {31'd0, busy}, 32'd0);
      chk("t3_ovr_sticky", {31'd0, overrun}, 32'd1);
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      chk("t3_clr", {31'd0, overrun}, 32'd0);

      // Last task done on the deadline cycle: no overrun
      task_mask = 4'b1001;
      frame_start();
      run_task(4'b0001, 1);
      step();
      chk("t4a_req3", {28'd0, task_req}, 32'h8);
      step();
      task_done = 4'b1000; vaddr = 10'd0; haddr = 10'd0;
      step();
      task_done = 4'b0000; vaddr = 10'd100; haddr = 10'd5;
      chk("t4a_ovr", {31'd0, overrun}, 32'd0);
      chk("t4a_req", {28'd0, task_req}, 32'd0);
      chk("t4a_busy", {31'd0, busy}, 32'd0);

      task_mask = 4'b0011;
      frame_start();
      run_task(4'b0001, 1);
      step();
      task_done = 4'b0010; vaddr = 10'd0; haddr = 10'd0;
      step();
      task_done = 4'b0000; vaddr = 10'd100; haddr = 10'd5;
      chk("t4b_ovr", {31'd0, overrun}, 32'd0);

      // Done at deadline but task 3 still pending
      task_mask = 4'b1010;
      frame_start();
      chk("t4c_req1", {28'd0, task_req}, 32'h2);
      step();
      task_done = 4'b0010; vaddr = 10'd0; haddr = 10'd0;
      step();
      task_done = 4'b0000; vaddr = 10'd100; haddr = 10'd5;
      chk("t4c_ovr", {31'd0, overrun}, 32'd1);
      chk("t4c_ovr_task", {30'd0, overrun_task}, 32'd3);
      chk("t4c_req", {28'd0, task_req}, 32'd0);
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;

      // Disabled or empty-mask frames still tick and count
      pulse_reset();
      for (int f = 0; f < 3; f++) begin
         enable    = (f != 0);
         task_mask = (f == 0) ? 4'b1111 : 4'b0000;
         frame_start();
         chk("t5_tick", {31'd0, frame_tick}, 32'd1);
         chk("t5_req", {28'd0, task_req}, 32'd0);
         step();
         chk("t5_tick_off", {31'd0, frame_tick}, 32'd0);
         chk("t5_req_later", {28'd0, task_req}, 32'd0);
         repeat (3) step();
      end
      chk("t5_fc", {16'd0, frame_count}, 32'd3);
      chk("t5_busy", {31'd0, busy}, 32'd0);

      // Asynchronous reset in the middle of a request
      enable = 1'b1; task_mask = 4'b0001;
      frame_start();
      chk("t6_req", {28'd0, task_req}, 32'h1);
      chk("t6_fc", {16'd0, frame_count}, 32'd4);
      sys_rst = 1'b1;
      #1;
      chk("t6_async_req", {28'd0, task_req}, 32'd0);
      chk("t6_async_fc", {16'd0, frame_count}, 32'd0);
      #1;
      sys_rst = 1'b0;
      step();

      // Clear and set on the same cycle: set wins
      task_mask = 4'b0100;
      frame_start();
      chk("t6_req2", {28'd0, task_req}, 32'h4);
      step();
      vaddr = 10'd0; haddr = 10'd0; overrun_clr = 1'b1;
      step();
      vaddr = 10'd100; haddr = 10'd5; overrun_clr = 1'b0;
      chk("t6_set_wins", {31'd0, overrun}, 32'd1);
      chk("t6_set_task", {30'd0, overrun_task}, 32'd2);
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      chk("t6_clr", {31'd0, overrun}, 32'd0);
      chk("t6_task_hold", {30'd0, overrun_task}, 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/p21_frame_sched.md
Name: p21_frame_sched

Overview:
Per-frame scheduler for dino-game logic. Watches the VGA timing generator's vaddr/haddr and, at the start of vertical blanking, runs up to NUM_TASKS game-logic engines (physics, collision, spawn, score) one at a time over a req/done handshake. If the vblank window closes before all tasks finish, it aborts the frame and flags an overrun. It sits between the VGA timing generator and the game-logic engines.

Parameters:
NUM_TASKS, 4, number of schedulable tasks; task i has priority over task i+1.
V_ACTIVE, 480, vaddr value that marks the start of vblank.
FC_W, 16, frame counter width.

Ports:
clk  in  1  system clock, pixel rate.
sys_rst  in  1  asynchronous, active-high reset.
enable  in  1  scheduler enable; sampled only at frame start.
vaddr  in  10  vertical address from the VGA timing generator.
haddr  in  10  horizontal address from the VGA timing generator.
task_mask  in  NUM_TASKS  per-task enable; latched at frame start.
task_req  out  NUM_TASKS  one-hot request to the task engines.
task_done  in  NUM_TASKS  completion pulse or level from the engines.
busy  out  1  high while a frame's task sequence is in progress.
frame_tick  out  1  one-cycle pulse at each frame start.
frame_count  out  FC_W  count of frame starts; wraps.
overrun  out  1  sticky deadline-miss flag.
overrun_task  out  clog2(NUM_TASKS)  index of the task that was active at the miss.
overrun_clr  in  1  clears overrun.

Behaviour:
- Reset, asynchronous: state=IDLE; task_req=0; busy=0; frame_tick=0; frame_count=0; overrun=0; overrun_task=0; latched mask=0. Reset mid-frame drops task_req immediately, with no gap cycle.
- Frame start event FS: vaddr==V_ACTIVE && haddr==0, sampled at a clock edge. Deadline event DL: vaddr==0 && haddr==0.
- FSM states: IDLE, REQ, GAP.
- IDLE:
  - on FS: frame_tick=1 in the next cycle, and frame_count increments (wraps at 2^FC_W-1 -> 0). This happens whether or not enable is set.
  - if enable on FS: latch task_mask and pick the lowest set index i. If one exists, go to REQ with task_req=onehot(i) and busy=1, in the same cycle as frame_tick. If none, stay IDLE.
- REQ:
  - task_req[i] is held high; task_done bits for other tasks are ignored.
  - on task_done[i]: task_req=0 next cycle, go to GAP.
- GAP, exactly one cycle with all requests low:
  - pick the next latched-mask bit with index > i. If found, go to REQ with the new one-hot request. If not, go to IDLE with busy=0.
- Latency: FS sampled at edge N -> task_req high from N+1. task_done sampled at edge M -> task_req low from M+1 -> next task_req from M+2.
- Deadline in REQ or GAP: go to IDLE, task_req=0, busy=0.
  - overrun=1 and overrun_task=i, unless the frame was complete that same cycle (see below).
- Simultaneous task_done[i] and DL in REQ: the task counts as complete. Overrun is set only if a later masked task remained; in that case overrun_task is the index of the next pending task.
- FS arriving while not IDLE (only possible with non-standard timing): ignored for task dispatch; frame_tick and frame_count still update.
- overrun_clr and an overrun set in the same cycle: set wins. overrun_task updates only on set.
- Mid-frame changes to task_mask or enable have no effect until the next FS.
- task_done held high across the GAP has no effect; only the currently requested index is observed.

Decomposition:
- Shared package p21_pkg: V_ACTIVE=480, V_TOTAL, H_TOTAL, the FS/DL coordinate constants, and the state enum (IDLE, REQ, GAP) as a typedef.
- One sub-module, p21_task_pick: combinational priority finder. Given mask, start index and an inclusive/exclusive flag, it returns found and idx.

Test Plan:
- mask=4'b1011, enable=1, each engine asserts done 3 cycles after its req -> req sequence 0001, gap, 0010, gap, 1000; busy falls after the third done; frame_count=1; overrun=0.
- Drive FS at edge 100 -> frame_tick and task_req[0] high at edge 101. Done at edge 110 -> all req low at 111, task_req[1] high at 112.
- mask=4'b0110, task 2 never responds -> at DL, overrun=1, overrun_task=2, task_req=0, state IDLE. The next FS restarts at task 1.
- Task 3 (last) asserts done in the same cycle as DL -> overrun stays 0. Repeat with task 1 of mask 4'b0011... rerun with mask 4'b1010 and task 1 done at DL -> overrun=1, overrun_task=3.
- enable=0 or mask=0 over 3 frames -> frame_count reaches 3, frame_tick pulses 3 times, task_req never asserts.
- Assert sys_rst mid-REQ -> task_req=0 and frame_count=0 asynchronously. Raise overrun_clr in the same cycle as a new overrun -> overrun=1.
